pll_ctrl: RTL and testbench

Supervisor and reconfiguration controller for the Gowin rPLL. It sequences PLL reset, waits for lock with timeout and retry, and qualifies lock stability before releasing downstream logic. It also switches between PROFILES divider sets via the rPLL dynamic IDSEL/FBDSEL/ODSEL inputs. It sits beside the rPLL instance in the top level, clocked by the free-running board reference clock, and gates the reset of everything clocked by the PLL output.

---
 rtl/pll_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pll_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_ctrl.sv
// Gowin rPLL supervisor: sequences PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, and applies divider profiles via the dynamic selects.
module pll_ctrl #(
  parameter int unsigned           PROFILES        = 4,
  parameter int unsigned           DEFAULT_PROFILE = 0,
  parameter logic [6*PROFILES-1:0] IDSEL_TABLE     = '0,
  parameter logic [6*PROFILES-1:0] FBDSEL_TABLE    = '0,
  parameter logic [6*PROFILES-1:0] ODSEL_TABLE     = '0,
  parameter int unsigned           RESET_HOLD      = 16,
  parameter int unsigned           LOCK_STABLE     = 1024,
  parameter int unsigned           LOCK_TIMEOUT    = 2700000,
  parameter int unsigned           MAX_RETRIES     = 3,
  localparam int unsigned          PW              = (PROFILES > 1) ? $clog2(PROFILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] sel_profile,
  input  logic          sel_valid,
  output logic          sel_ready,
  input  logic          pll_lock,
  output logic          pll_reset,
  output logic [5:0]    pll_idsel,
  output logic [5:0]    pll_fbdsel,
  output logic [5:0]    pll_odsel,
  output logic [PW-1:0] active_profile,
  output logic          clk_ok,
  output logic          rst_out,
  output logic          fault
);

  localparam int unsigned HW = $clog2(RESET_HOLD + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [PW-1:0] prof_q, prof_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q, lock_s_d;
  logic          pll_reset_q, pll_reset_d;
  logic          clk_ok_q, clk_ok_d;
  logic          rst_out_q, rst_out_d;
  logic          fault_q, fault_d;
  logic          sel_ready_q, sel_ready_d;
  logic [5:0]    idsel_q, idsel_d;
  logic [5:0]    fbdsel_q, fbdsel_d;
  logic [5:0]    odsel_q, odsel_d;

  logic          accept;
  logic          tmo_hit;
  logic [31:0]   sel_idx;
  logic [31:0]   prof_idx;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    stab_d      = stab_q;
    tmo_d       = tmo_q;
    retries_d   = retries_q;
    prof_d      = prof_q;
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
    accept      = sel_valid && sel_ready_q;
    sel_idx     = 32'(sel_profile);
    tmo_hit     = (tmo_q == TW'(LOCK_TIMEOUT - 1));

    case (state_q)
      S_RESET_PLL: begin
        if (hold_q == HW'(RESET_HOLD - 1)) state_d = S_WAIT_LOCK;
        else                               hold_d  = hold_q + 1'b1;
      end
      S_WAIT_LOCK, S_STABLE: begin
        tmo_d = tmo_q + 1'b1;
        // Priority: stable completion (needs lock), lock rise, timeout, lock fall.
        if (state_q == S_STABLE && lock_s_q && stab_q == SW'(LOCK_STABLE - 1)) begin
          state_d   = S_RUN;
          retries_d = '0;
        end else if (state_q == S_WAIT_LOCK && lock_s_q) begin
          state_d = S_STABLE;
          stab_d  = '0;
        end else if (tmo_hit) begin
          retries_d = retries_q + 1'b1;
          state_d   = (retries_q == RW'(MAX_RETRIES - 1)) ? S_FAULT : S_RESET_PLL;
        end else if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) state_d = S_RESET_PLL;
      end
      default: ;
    endcase

    if (accept && sel_idx < PROFILES) begin
      state_d   = S_RESET_PLL;
      prof_d    = sel_profile;
      retries_d = '0;
    end

    if (state_d == S_RESET_PLL && state_q != S_RESET_PLL) begin
      hold_d = '0;
      tmo_d  = '0;
    end

    prof_idx    = 32'(prof_d);
    idsel_d     = IDSEL_TABLE[6*prof_idx +: 6];
    fbdsel_d    = FBDSEL_TABLE[6*prof_idx +: 6];
    odsel_d     = ODSEL_TABLE[6*prof_idx +: 6];
    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    clk_ok_d    = (state_d == S_RUN);
    rst_out_d   = (state_d != S_RUN);
    fault_d     = (state_d == S_FAULT);
    sel_ready_d = (state_d == S_RUN) || (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      hold_q      <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      retries_q   <= '0;
      prof_q      <= PW'(DEFAULT_PROFILE);
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      clk_ok_q    <= 1'b0;
      rst_out_q   <= 1'b1;
      fault_q     <= 1'b0;
      sel_ready_q <= 1'b0;
      idsel_q     <= IDSEL_TABLE[6*DEFAULT_PROFILE +: 6];
      fbdsel_q    <= FBDSEL_TABLE[6*DEFAULT_PROFILE +: 6];
      odsel_q     <= ODSEL_TABLE[6*DEFAULT_PROFILE +: 6];
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      retries_q   <= retries_d;
      prof_q      <= prof_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      clk_ok_q    <= clk_ok_d;
      rst_out_q   <= rst_out_d;
      fault_q     <= fault_d;
      sel_ready_q <= sel_ready_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
    end
  end

  assign pll_reset      = pll_reset_q;
  assign clk_ok         = clk_ok_q;
  assign rst_out        = rst_out_q;
  assign fault          = fault_q;
  assign sel_ready      = sel_ready_q;
  assign pll_idsel      = idsel_q;
  assign pll_fbdsel     = fbdsel_q;
  assign pll_odsel      = odsel_q;
  assign active_profile = prof_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl; a second 5-profile instance covers an out-of-range request index.
module tb_pll_ctrl;

  localparam logic [23:0] ID4 = {6'd13, 6'd12, 6'd11, 6'd10};
  localparam logic [23:0] FB4 = {6'd23, 6'd22, 6'd21, 6'd20};
  localparam logic [23:0] OD4 = {6'd33, 6'd32, 6'd31, 6'd30};
  localparam logic [29:0] ID5 = {6'd44, 6'd43, 6'd42, 6'd41, 6'd40};
  localparam logic [29:0] FB5 = {6'd54, 6'd53, 6'd52, 6'd51, 6'd50};
  localparam logic [29:0] OD5 = {6'd63, 6'd62, 6'd61, 6'd60, 6'd59};

  logic       clk = 1'b0;
  logic       rst, pll_lock;
  logic [1:0] sel_profile;
  logic       sel_valid, sel_ready, pll_reset, clk_ok, rst_out, fault;
  logic [5:0] idsel, fbdsel, odsel;
  logic [1:0] active_profile;

  logic [2:0] sel_profile5, active_profile5;
  logic       sel_valid5, sel_ready5, pll_reset5, clk_ok5, rst_out5, fault5;
  logic [5:0] idsel5, fbdsel5, odsel5;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned hi, cyc;

  always #5 clk = ~clk;

  pll_ctrl #(
    .PROFILES(4), .DEFAULT_PROFILE(0),
    .IDSEL_TABLE(ID4), .FBDSEL_TABLE(FB4), .ODSEL_TABLE(OD4),
    .RESET_HOLD(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRIES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .sel_profile(sel_profile), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(idsel), .pll_fbdsel(fbdsel), .pll_odsel(odsel),
    .active_profile(active_profile), .clk_ok(clk_ok), .rst_out(rst_out), .fault(fault)
  );

  pll_ctrl #(
    .PROFILES(5), .DEFAULT_PROFILE(0),
    .IDSEL_TABLE(ID5), .FBDSEL_TABLE(FB5), .ODSEL_TABLE(OD5),
    .RESET_HOLD(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRIES(2)
  ) u_dut5 (
    .clk(clk), .rst(rst), .sel_profile(sel_profile5), .sel_valid(sel_valid5),
    .sel_ready(sel_ready5), .pll_lock(pll_lock), .pll_reset(pll_reset5),
    .pll_idsel(idsel5), .pll_fbdsel(fbdsel5), .pll_odsel(odsel5),
    .active_profile(active_profile5), .clk_ok(clk_ok5), .rst_out(rst_out5), .fault(fault5)
  );

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_clk_ok"},    32'(clk_ok), 0);
    chk({tag, "_rst_out"},   32'(rst_out), 1);
    chk({tag, "_fault"},     32'(fault), 0);
    chk({tag, "_sel_ready"}, 32'(sel_ready), 0);
    chk({tag, "_profile"},   32'(active_profile), 0);
    chk({tag, "_idsel"},     32'(idsel), 10);
    chk({tag, "_fbdsel"},    32'(fbdsel), 20);
    chk({tag, "_odsel"},     32'(odsel), 30);
  endtask

  initial begin
    rst = 1'b1; pll_lock = 1'b0;
    sel_valid = 1'b0; sel_profile = '0;
    sel_valid5 = 1'b0; sel_profile5 = '0;
    step(3);
    chk_reset_vals("por");

    // Release reset (edge 0 is the last edge that sampled rst high); lock rises after edge 10.
    rst = 1'b0;
    hi = 32'(pll_reset);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (pll_reset) hi++;
    end
    chk("hold_cycles", hi, 4);
    pll_lock = 1'b1;
    cyc = 10;
    while (!clk_ok && cyc < 60) begin
      step(1);
      cyc++;
    end
    chk("clk_ok_rise_cycle", cyc, 21);
    chk("run_rst_out", 32'(rst_out), 0);
    chk("run_fault", 32'(fault), 0);
    chk("run_sel_ready", 32'(sel_ready), 1);
    chk("run_pll_reset", 32'(pll_reset), 0);

    // Out-of-range index on the 5-profile instance: handshake only.
    chk("bad_ready_before", 32'(sel_ready5), 1);
    sel_profile5 = 3'd5; sel_valid5 = 1'b1;
    step(1);
    sel_valid5 = 1'b0;
    chk("bad_clk_ok", 32'(clk_ok5), 1);
    chk("bad_pll_reset", 32'(pll_reset5), 0);
    chk("bad_sel_ready", 32'(sel_ready5), 1);
    chk("bad_profile", 32'(active_profile5), 0);
    chk("bad_idsel", 32'(idsel5), 40);
    chk("bad_fbdsel", 32'(fbdsel5), 50);
    chk("bad_odsel", 32'(odsel5), 59);
    step(3);
    chk("bad_clk_ok_later", 32'(clk_ok5), 1);

    // Switch to profile 2 while in RUN.
    sel_profile = 2'd2; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    chk("sw_pll_reset", 32'(pll_reset), 1);
    chk("sw_clk_ok", 32'(clk_ok), 0);
    chk("sw_rst_out", 32'(rst_out), 1);
    chk("sw_sel_ready", 32'(sel_ready), 0);
    chk("sw_profile", 32'(active_profile), 2);
    chk("sw_idsel", 32'(idsel), 12);
    chk("sw_fbdsel", 32'(fbdsel), 22);
    chk("sw_odsel", 32'(odsel), 32);
    cyc = 0;
    while (!clk_ok && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("sw_relock_cycles", cyc, 13);
    chk("sw_idsel_run", 32'(idsel), 12);

    // Lock drop in RUN (3 cycles), then a 3-cycle glitch during STABLE.
    pll_lock = 1'b0;
    step(2);
    chk("drop_clk_ok_m2", 32'(clk_ok), 1);
    step(1);
    chk("drop_clk_ok_m3", 32'(clk_ok), 0);
    chk("drop_pll_reset_m3", 32'(pll_reset), 1);
    chk("drop_sel_ready_m3", 32'(sel_ready), 0);
    pll_lock = 1'b1;
    step(3);
    chk("drop_pll_reset_m6", 32'(pll_reset), 1);
    step(1);
    chk("drop_pll_reset_m7", 32'(pll_reset), 0);
    step(3);
    pll_lock = 1'b0;
    step(3);
    chk("glitch_pll_reset", 32'(pll_reset), 0);
    chk("glitch_clk_ok", 32'(clk_ok), 0);
    pll_lock = 1'b1;
    step(10);
    chk("glitch_clk_ok_m23", 32'(clk_ok), 0);
    step(1);
    chk("glitch_clk_ok_m24", 32'(clk_ok), 1);

    // rst in RUN with a simultaneous request: request discarded.
    rst = 1'b1; sel_profile = 2'd3; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    chk_reset_vals("rst_run");

    // No lock: two attempts of 4+100 cycles, then FAULT.
    pll_lock = 1'b0;
    rst = 1'b0;
    step(4);
    chk("nl_pll_reset_e4", 32'(pll_reset), 0);
    step(99);
    chk("nl_pll_reset_e103", 32'(pll_reset), 0);
    step(1);
    chk("nl_pll_reset_e104", 32'(pll_reset), 1);
    step(3);
    chk("nl_pll_reset_e107", 32'(pll_reset), 1);
    step(1);
    chk("nl_pll_reset_e108", 32'(pll_reset), 0);
    step(99);
    chk("nl_fault_e207", 32'(fault), 0);
    step(1);
    chk("nl_fault", 32'(fault), 1);
    chk("nl_pll_reset", 32'(pll_reset), 1);
    chk("nl_sel_ready", 32'(sel_ready), 1);
    chk("nl_clk_ok", 32'(clk_ok), 0);
    chk("nl_rst_out", 32'(rst_out), 1);

    // Request in FAULT clears fault and retries; two fresh attempts follow.
    sel_profile = 2'd1; sel_valid = 1'b1;
    step(1);
    sel_valid = 1'b0;
    chk("fr_fault", 32'(fault), 0);
    chk("fr_pll_reset", 32'(pll_reset), 1);
    chk("fr_profile", 32'(active_profile), 1);
    chk("fr_idsel", 32'(idsel), 11);
    step(207);
    chk("fr_fault_n207", 32'(fault), 0);
    step(1);
    chk("fr_fault_n208", 32'(fault), 1);

    // rst in FAULT.
    rst = 1'b1;
    step(1);
    chk_reset_vals("rst_fault");
    rst = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
